// File: rtl/hcount_sink.sv
// hcount_sink: terminal consumer of a two-phase req/ack message channel.
// Acknowledges every message, checks redundancy and destination address,
// and keeps wrapping message / saturating error counters.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 32
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

module hcount_sink #(
   parameter int ASZ       = `NS_ADDRESS_SIZE,
   parameter int DSZ       = `NS_DATA_SIZE,
   parameter int RSZ       = `NS_REDUN_SIZE,
   parameter int CSZ       = 16,
   parameter int MY_ADDR   = 0,
   parameter int CHK_DST   = 1,
   parameter int ACK_DELAY = 0
) (
   input  logic           gch_clk,
   input  logic           gch_reset,
   output logic           gch_ready,
   input  logic [ASZ-1:0] rcv0_src,
   input  logic [ASZ-1:0] rcv0_dst,
   input  logic [DSZ-1:0] rcv0_dat,
   input  logic [RSZ-1:0] rcv0_red,
   input  logic           rcv0_req_in,
   output logic           rcv0_ack_out,
   output logic [CSZ-1:0] msg_cnt,
   output logic [CSZ-1:0] err_cnt,
   output logic           err_flag,
   output logic [DSZ-1:0] last_dat
);

   localparam logic [1:0] S_INIT = 2'd0;
   localparam logic [1:0] S_IDLE = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   // widest of the summed fields; the sum is reduced modulo 2^RSZ afterwards
   localparam int AW = (ASZ > DSZ) ? ASZ : DSZ;
   localparam int WW = (AW > RSZ) ? AW : RSZ;

   logic [1:0]     state_q, state_d;
   logic           ready_q, ready_d;
   logic           ack_q, ack_d;
   logic [ASZ-1:0] src_q, src_d;
   logic [ASZ-1:0] dst_q, dst_d;
   logic [DSZ-1:0] dat_q, dat_d;
   logic [RSZ-1:0] red_q, red_d;
   logic [7:0]     dly_q, dly_d;
   logic [CSZ-1:0] msg_q, msg_d;
   logic [CSZ-1:0] err_q, err_d;
   logic           flag_q, flag_d;
   logic [DSZ-1:0] last_q, last_d;

   logic           pending;
   logic [RSZ-1:0] red_exp;
   logic           red_bad;
   logic           misroute;
   logic           msg_err;

   // error classification of the captured message
   always_comb begin
      pending  = (rcv0_req_in != ack_q);
      red_exp  = RSZ'(WW'(src_q) + WW'(dst_q) + WW'(dat_q));
      red_bad  = (red_exp != red_q);
      misroute = (CHK_DST != 0) && (dst_q != ASZ'(MY_ADDR));
      msg_err  = red_bad | misroute;
   end

   // handshake FSM and counter next-state
   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      ack_d   = ack_q;
      src_d   = src_q;
      dst_d   = dst_q;
      dat_d   = dat_q;
      red_d   = red_q;
      dly_d   = dly_q;
      msg_d   = msg_q;
      err_d   = err_q;
      flag_d  = flag_q;
      last_d  = last_q;
      case (state_q)
         S_INIT: begin
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
         S_IDLE: begin
            if (pending) begin
               src_d   = rcv0_src;
               dst_d   = rcv0_dst;
               dat_d   = rcv0_dat;
               red_d   = rcv0_red;
               dly_d   = 8'(ACK_DELAY);
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (dly_q != 8'd0) begin
               dly_d = dly_q - 8'd1;
            end else begin
               ack_d  = ~ack_q;
               msg_d  = msg_q + CSZ'(1);
               last_d = dat_q;
               if (msg_err) begin
                  if (err_q != '1) err_d = err_q + CSZ'(1);
                  flag_d = 1'b1;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // state registers with synchronous reset taking priority
   always_ff @(posedge gch_clk) begin
      if (gch_reset) begin
         state_q <= S_INIT;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         dat_q   <= '0;
         red_q   <= '0;
         dly_q   <= '0;
         msg_q   <= '0;
         err_q   <= '0;
         flag_q  <= 1'b0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         ack_q   <= ack_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         dat_q   <= dat_d;
         red_q   <= red_d;
         dly_q   <= dly_d;
         msg_q   <= msg_d;
         err_q   <= err_d;
         flag_q  <= flag_d;
         last_q  <= last_d;
      end
   end

   assign gch_ready    = ready_q;
   assign rcv0_ack_out = ack_q;
   assign msg_cnt      = msg_q;
   assign err_cnt      = err_q;
   assign err_flag     = flag_q;
   assign last_dat     = last_q;

endmodule

// File: tb/tb_hcount_sink.sv
// Scoreboard bench for hcount_sink: two instances (ACK_DELAY 0 / CSZ 4 and
// ACK_DELAY 3 / CSZ 16). Drivers push expected per-ack results; monitors
// pop and compare whenever an ack toggle is observed.

module tb_hcount_sink;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] src, dst, red;
   logic [7:0] dat;
   logic       req0, req1;

   logic        ready0, ack0, flag0;
   logic [3:0]  cnt0, err0;
   logic [7:0]  last0;
   logic        ready1, ack1, flag1;
   logic [15:0] cnt1, err1;
   logic [7:0]  last1;

   typedef struct {
      int        cyc;
      int        mc;
      int        ec;
      int        ef;
      int        ld;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int cyc = 0;
   int nchk = 0;
   int nerr = 0;
   int m_mc[2];
   int m_ec[2];
   int m_ef[2];
   logic a0p = 1'b0;
   logic a1p = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hcount_sink #(.ASZ(4), .DSZ(8), .RSZ(4), .CSZ(4), .MY_ADDR(2),
                 .CHK_DST(1), .ACK_DELAY(0)) dut0 (
      .gch_clk(clk), .gch_reset(rst), .gch_ready(ready0),
      .rcv0_src(src), .rcv0_dst(dst), .rcv0_dat(dat), .rcv0_red(red),
      .rcv0_req_in(req0), .rcv0_ack_out(ack0),
      .msg_cnt(cnt0), .err_cnt(err0), .err_flag(flag0), .last_dat(last0));

   hcount_sink #(.ASZ(4), .DSZ(8), .RSZ(4), .CSZ(16), .MY_ADDR(2),
                 .CHK_DST(1), .ACK_DELAY(3)) dut1 (
      .gch_clk(clk), .gch_reset(rst), .gch_ready(ready1),
      .rcv0_src(src), .rcv0_dst(dst), .rcv0_dat(dat), .rcv0_red(red),
      .rcv0_req_in(req1), .rcv0_ack_out(ack1),
      .msg_cnt(cnt1), .err_cnt(err1), .err_flag(flag1), .last_dat(last1));

   task automatic chk(input string nm, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // monitor for instance 0
   always @(negedge clk) begin
      if (rst) a0p = ack0;
      else if (ack0 !== a0p) begin
         a0p = ack0;
         if (q0.size() == 0) chk("ack0_unexpected", 1, 0);
         else begin
            exp_t e;
            e = q0.pop_front();
            chk("ack0_cycle", cyc, e.cyc);
            chk("msg_cnt0", cnt0, e.mc);
            chk("err_cnt0", err0, e.ec);
            chk("err_flag0", flag0, e.ef);
            chk("last_dat0", last0, e.ld);
         end
      end
   end

   // monitor for instance 1
   always @(negedge clk) begin
      if (rst) a1p = ack1;
      else if (ack1 !== a1p) begin
         a1p = ack1;
         if (q1.size() == 0) chk("ack1_unexpected", 1, 0);
         else begin
            exp_t e;
            e = q1.pop_front();
            chk("ack1_cycle", cyc, e.cyc);
            chk("msg_cnt1", cnt1, e.mc);
            chk("err_cnt1", err1, e.ec);
            chk("err_flag1", flag1, e.ef);
            chk("last_dat1", last1, e.ld);
         end
      end
   end

   function automatic logic cur_ack(input int i);
      return (i == 0) ? ack0 : ack1;
   endfunction

   function automatic logic cur_req(input int i);
      return (i == 0) ? req0 : req1;
   endfunction

   // called at a negedge; returns at a negedge one cycle after toggling req
   task automatic send(input int i, input logic [3:0] s, input logic [3:0] d,
                       input logic [7:0] dt, input logic [3:0] r, input bit exp_ack);
      int n = 0;
      exp_t e;
      logic [3:0] good;
      int cmask, dly;
      while (cur_ack(i) != cur_req(i) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("send_wait", 1, 0);
      src = s; dst = d; dat = dt; red = r;
      if (i == 0) req0 = ~req0; else req1 = ~req1;
      if (exp_ack) begin
         cmask = (i == 0) ? 'hF : 'hFFFF;
         dly   = (i == 0) ? 0 : 3;
         good  = s + d + dt[3:0] + dt[7:4] * 4'd0;
         m_mc[i] = (m_mc[i] + 1) & cmask;
         if (good != r || d != 4'd2) begin
            if (m_ec[i] != cmask) m_ec[i]++;
            m_ef[i] = 1;
         end
         e.cyc = cyc + dly + 2;
         e.mc = m_mc[i]; e.ec = m_ec[i]; e.ef = m_ef[i]; e.ld = dt;
         if (i == 0) q0.push_back(e); else q1.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic drain(input int i);
      int n = 0;
      while (((i == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk((i == 0) ? "drain0" : "drain1", (i == 0) ? q0.size() : q1.size(), 0);
   endtask

   task automatic zero_check(input string tag);
      chk({tag, "_ready0"}, ready0, 0);
      chk({tag, "_ack0"}, ack0, 0);
      chk({tag, "_cnt0"}, cnt0, 0);
      chk({tag, "_err0"}, err0, 0);
      chk({tag, "_flag0"}, flag0, 0);
      chk({tag, "_last0"}, last0, 0);
      chk({tag, "_ready1"}, ready1, 0);
      chk({tag, "_cnt1"}, cnt1, 0);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mc[k] = 0; m_ec[k] = 0; m_ef[k] = 0;
      end
   endtask

   initial begin
      int bad;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      src = '0; dst = '0; dat = '0; red = '0;
      model_reset();
      repeat (3) @(negedge clk);
      zero_check("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("ready0_after_init", ready0, 1);
      chk("ready1_after_init", ready1, 1);
      chk("ack0_after_init", ack0, 0);

      // good, bad red, misrouted, both errors (1+2+0x15 = 0x18 -> 8)
      send(0, 4'd1, 4'd2, 8'h15, 4'h8, 1);
      send(0, 4'd1, 4'd2, 8'h15, 4'h9, 1);
      send(0, 4'd1, 4'd3, 8'h15, 4'h9, 1);
      send(0, 4'd1, 4'd3, 8'h15, 4'h0, 1);
      drain(0);
      chk("err_cnt0_after_four", err0, 3);
      chk("msg_cnt0_after_four", cnt0, 4);

      rst = 1'b1; req0 = 1'b0;
      repeat (2) @(negedge clk);
      zero_check("reset2");
      model_reset();
      rst = 1'b0;
      @(negedge clk);

      // 20 bad-red messages: msg_cnt wraps to 4, err_cnt saturates at 15
      for (int k = 0; k < 20; k++)
         send(0, 4'd1, 4'd2, 8'(k), 4'(3 + k + 1), 1);
      drain(0);
      chk("msg_cnt0_wrapped", cnt0, 4);
      chk("err_cnt0_saturated", err0, 15);
      chk("err_flag0_sticky", flag0, 1);

      // 21st message: reset lands on the edge that would acknowledge it
      send(0, 4'd1, 4'd2, 8'h21, 4'h0, 0);
      rst = 1'b1; req0 = 1'b0;
      @(negedge clk);
      chk("midhold_ack0", ack0, 0);
      chk("midhold_cnt0", cnt0, 0);
      chk("midhold_err0", err0, 0);
      chk("midhold_flag0", flag0, 0);
      model_reset();
      rst = 1'b0;
      @(negedge clk);

      // idle upstream on instance 1
      bad = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (ready1 !== 1'b1 || ack1 !== 1'b0 || cnt1 !== 16'd0) bad++;
      end
      chk("idle_bad_cycles", bad, 0);

      // ten valid messages with ACK_DELAY=3
      for (int k = 0; k < 10; k++) begin
         logic [7:0] d8;
         d8 = 8'(k * 7);
         send(1, 4'(k), 4'd2, d8, 4'(k + 2 + k * 7), 1);
      end
      drain(1);
      chk("msg_cnt1_final", cnt1, 10);
      chk("err_cnt1_final", err1, 0);
      chk("ack0_quiet", q0.size(), 0);
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
